// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_master write engine between NUM_REQ requesters,
// with NACK retry after a back-off, a per-attempt watchdog and per-requester completion pulses.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_RETRY      = 2,
    parameter int BACKOFF_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*7-1:0]   req_addr_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    output logic [1:0]             resp_status_o,
    output logic [2:0]             resp_retries_o,
    output logic                   busy_o,
    output logic                   m_start_o,
    output logic [6:0]             m_slave_addr_o,
    output logic [7:0]             m_data_o,
    input  logic                   m_busy_i,
    input  logic                   m_done_i,
    input  logic [1:0]             m_error_i
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int RETRY_W = $clog2(MAX_RETRY) + 1;
    localparam int BO_W    = $clog2(BACKOFF_CYCLES) + 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NACK_ADDR = 2'd1,
        ST_NACK_DATA = 2'd2,
        ST_BUS_ERROR = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_BACKOFF,
        S_RESPOND
    } state_e;

    state_e               state;
    state_e               next_state;
    status_e              status_q;
    status_e              next_status;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [BO_W-1:0]      bo_cnt;
    logic [WD_W-1:0]      wd_cnt;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;
    logic                 retry_now;
    logic                 is_nack;
    logic                 wd_expired;
    logic                 bo_done;

    logic [6:0]           addr_arr [NUM_REQ];
    logic [7:0]           data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k] = req_addr_i[7*k +: 7];
        assign data_arr[k] = req_data_i[8*k +: 8];
    end

    assign is_nack    = (m_error_i == ST_NACK_ADDR) || (m_error_i == ST_NACK_DATA);
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign bo_done    = (bo_cnt == BO_W'(BACKOFF_CYCLES - 1));

    // First requesting index at or after the pointer, scanning with wrap-around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && req_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        next_state  = state;
        next_status = status_q;
        retry_now   = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_found) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // done/error are deliberately ignored here: they may be left over from the last transfer
                if (wd_expired) begin
                    next_status = ST_BUS_ERROR;
                    next_state  = S_RESPOND;
                end else if (m_busy_i) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (m_error_i != ST_OK) begin
                    if (is_nack && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                        retry_now  = 1'b1;
                        next_state = S_BACKOFF;
                    end else begin
                        next_status = status_e'(m_error_i);
                        next_state  = S_RESPOND;
                    end
                end else if (m_done_i) begin
                    next_status = ST_OK;
                    next_state  = S_RESPOND;
                end else if (wd_expired) begin
                    next_status = ST_BUS_ERROR;
                    next_state  = S_RESPOND;
                end
            end
            S_BACKOFF: begin
                if (bo_done) next_state = S_ISSUE;
            end
            S_RESPOND: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            status_q       <= ST_OK;
            gnt_q          <= '0;
            gnt_idx        <= '0;
            rr_ptr         <= '0;
            retry_cnt      <= '0;
            bo_cnt         <= '0;
            wd_cnt         <= '0;
            m_slave_addr_o <= '0;
            m_data_o       <= '0;
        end else begin
            state    <= next_state;
            status_q <= next_status;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt_idx        <= sel_idx;
                        gnt_q          <= NUM_REQ'(1) << sel_idx;
                        m_slave_addr_o <= addr_arr[sel_idx];
                        m_data_o       <= data_arr[sel_idx];
                        retry_cnt      <= '0;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                S_WAIT_DONE: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (retry_now) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        bo_cnt    <= '0;
                    end
                end
                S_BACKOFF: begin
                    bo_cnt <= bo_cnt + BO_W'(1);
                end
                S_RESPOND: begin
                    // Moving past the served requester is what keeps a busy requester from starving the rest
                    gnt_q  <= '0;
                    rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign resp_valid_o   = (state == S_RESPOND) ? gnt_q : '0;
    assign resp_status_o  = status_q;
    assign resp_retries_o = 3'(retry_cnt);
    assign busy_o         = (state != S_IDLE);
    assign m_start_o      = (state == S_ISSUE);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized scoreboard bench for i2c_txn_arbiter: a transfer-level model predicts grant order,
// attempts and final status; a master model answers start pulses and a monitor checks every output event.
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int MR = 2;
    localparam int BO = 8;
    localparam int TO = 100;
    localparam int NUM_TRANSFERS = 40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*7-1:0] req_addr_i = '0;
    logic [N*8-1:0] req_data_i = '0;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   resp_valid_o;
    logic [1:0]     resp_status_o;
    logic [2:0]     resp_retries_o;
    logic           busy_o;
    logic           m_start_o;
    logic [6:0]     m_slave_addr_o;
    logic [7:0]     m_data_o;
    logic           m_busy_i = 1'b0;
    logic           m_done_i = 1'b0;
    logic [1:0]     m_error_i = 2'd0;

    i2c_txn_arbiter #(
        .NUM_REQ(N), .MAX_RETRY(MR), .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .gnt_o(gnt_o), .resp_valid_o(resp_valid_o),
        .resp_status_o(resp_status_o), .resp_retries_o(resp_retries_o),
        .busy_o(busy_o), .m_start_o(m_start_o),
        .m_slave_addr_o(m_slave_addr_o), .m_data_o(m_data_o),
        .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_error_i(m_error_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {O_ACK, O_NACK_A, O_NACK_D, O_BUS_ERR, O_HANG, O_HANG_BUSY} outcome_e;
    typedef struct { outcome_e kind; bit retry_after; } attempt_t;
    typedef struct { int idx; logic [6:0] addr; logic [7:0] data; } start_t;
    typedef struct { int idx; logic [1:0] status; int retries; bit timed_out; } resp_t;

    attempt_t mq[$];
    start_t   sq[$];
    resp_t    rq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    bit expect_gap = 0;
    bit finished = 0;

    bit [N-1:0] pending = '0;
    logic [6:0] m_addr [N];
    logic [7:0] m_data [N];
    int ptr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: event occurred, expected none", name);
    endtask

    task automatic finish_run();
        if (!finished) begin
            finished = 1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        end
        $finish;
    endtask

    function automatic int next_grant();
        for (int i = 0; i < N; i++)
            if (pending[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [1:0] err_code(input outcome_e o);
        case (o)
            O_NACK_A:  return 2'd1;
            O_NACK_D:  return 2'd2;
            O_BUS_ERR: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    task automatic raise_req(input int k);
        pending[k] = 1'b1;
        m_addr[k] = 7'($urandom_range(1, 127));
        m_data[k] = 8'($urandom_range(1, 255));
        req_addr_i[k*7 +: 7] = m_addr[k];
        req_data_i[k*8 +: 8] = m_data[k];
        req_i[k] = 1'b1;
    endtask

    // Reference: each attempt either ends the transfer or, for a NACK with budget left, retries.
    task automatic plan_transfer(input int g, input int forced);
        int retries;
        int roll;
        bit done;
        outcome_e o;
        attempt_t a;
        start_t s;
        resp_t r;
        logic [1:0] st;
        retries = 0;
        done = 0;
        st = 2'd0;
        o = O_ACK;
        while (!done) begin
            if (forced >= 0) o = outcome_e'(forced);
            else begin
                roll = $urandom_range(0, 9);
                o = (roll < 4) ? O_ACK : (roll < 6) ? O_NACK_A : (roll < 8) ? O_NACK_D :
                    (roll < 9) ? O_BUS_ERR : O_HANG;
            end
            a.kind = o;
            a.retry_after = 0;
            case (o)
                O_ACK: begin st = 2'd0; done = 1; end
                O_NACK_A, O_NACK_D: begin
                    if (retries < MR) begin retries++; a.retry_after = 1; end
                    else begin st = err_code(o); done = 1; end
                end
                default: begin st = 2'd3; done = 1; end
            endcase
            s.idx = g; s.addr = m_addr[g]; s.data = m_data[g];
            sq.push_back(s);
            mq.push_back(a);
        end
        r.idx = g; r.status = st; r.retries = retries; r.timed_out = (o == O_HANG);
        rq.push_back(r);
        pending[g] = 1'b0;
        ptr = (g + 1) % N;
    endtask

    task automatic wait_resp(input int g, input bit drop);
        bit ok;
        bit dropped;
        ok = 0;
        dropped = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (drop && !dropped && m_start_o) begin
                req_i[g] = 1'b0;
                req_addr_i[g*7 +: 7] = 7'($urandom);
                req_data_i[g*8 +: 8] = 8'($urandom);
                dropped = 1;
            end
            if (resp_valid_o != '0) begin ok = 1; break; end
        end
        if (!ok) begin
            check("resp_timeout", 32'd0, 32'd1);
            finish_run();
        end
    endtask

    // Master model: answers each start with the next scripted attempt outcome.
    initial begin : master
        attempt_t a;
        forever begin
            @(negedge clk);
            if (rst && m_start_o) begin
                if (mq.size() == 0) begin
                    note_fail("master_unexpected_start");
                    continue;
                end
                a = mq.pop_front();
                m_busy_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                if (a.kind == O_HANG) continue;
                m_done_i = 1'b0;
                m_error_i = 2'd0;
                m_busy_i = 1'b1;
                if (a.kind == O_HANG_BUSY) continue;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                m_busy_i = 1'b0;
                m_done_i = 1'b1;
                m_error_i = err_code(a.kind);
                done_cyc = cyc;
                expect_gap = a.retry_after;
                if ($urandom_range(0, 1) == 0) begin
                    @(negedge clk);
                    m_done_i = 1'b0;
                    m_error_i = 2'd0;
                end
            end
        end
    end

    initial begin : monitor
        start_t s;
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m_start_o) begin
                    if (sq.size() == 0) note_fail("unexpected_start");
                    else begin
                        s = sq.pop_front();
                        check("start_addr", 32'(m_slave_addr_o), 32'(s.addr));
                        check("start_data", 32'(m_data_o), 32'(s.data));
                        check("start_gnt", 32'(gnt_o), 32'(1 << s.idx));
                        if (expect_gap) check("backoff_gap", cyc - done_cyc, BO + 1);
                    end
                    expect_gap = 0;
                    start_cyc = cyc;
                end
                if (resp_valid_o != '0) begin
                    if (rq.size() == 0) note_fail("unexpected_resp");
                    else begin
                        r = rq.pop_front();
                        check("resp_valid", 32'(resp_valid_o), 32'(1 << r.idx));
                        check("resp_status", 32'(resp_status_o), 32'(r.status));
                        check("resp_retries", 32'(resp_retries_o), r.retries);
                        check("busy_in_resp", 32'(busy_o), 32'd1);
                        if (r.timed_out) check("watchdog_latency", cyc - start_cyc, TO + 1);
                        else check("resp_latency", cyc - done_cyc, 1);
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
        check({tag, "_start"}, 32'(m_start_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_status"}, 32'(resp_status_o), 32'd0);
        check({tag, "_retries"}, 32'(resp_retries_o), 32'd0);
        check({tag, "_addr"}, 32'(m_slave_addr_o), 32'd0);
        check({tag, "_data"}, 32'(m_data_o), 32'd0);
    endtask

    task automatic applyStimulus();
        int g;
        bit drop;
        bit ok;
        for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) raise_req(k);
        if (pending == '0) raise_req(int'($urandom_range(0, N - 1)));
        for (int t = 0; t < NUM_TRANSFERS; t++) begin
            g = next_grant();
            drop = ($urandom_range(0, 3) == 0);
            plan_transfer(g, -1);
            wait_resp(g, drop);
            req_i[g] = 1'b0;
            if (t == NUM_TRANSFERS - 1) begin
                req_i = '0;
                pending = '0;
            end else begin
                for (int k = 0; k < N; k++)
                    if (!pending[k] && $urandom_range(0, 2) == 0) raise_req(k);
                if (pending == '0) raise_req(int'($urandom_range(0, N - 1)));
            end
        end
        repeat (3) @(negedge clk);
        check("idle_after_drain", 32'(busy_o), 32'd0);

        // Leave the DUT pointer at 3, then abandon a transfer of requester 0 with reset.
        raise_req(2);
        g = next_grant();
        plan_transfer(g, int'(O_ACK));
        wait_resp(g, 0);
        req_i[2] = 1'b0;
        repeat (2) @(negedge clk);
        raise_req(0);
        g = next_grant();
        plan_transfer(g, int'(O_HANG_BUSY));
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (m_busy_i) begin ok = 1; break; end
        end
        if (!ok) begin
            check("busy_timeout", 32'd0, 32'd1);
            finish_run();
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        sq.delete();
        mq.delete();
        rq.delete();
        expect_gap = 0;
        req_i = '0;
        pending = '0;
        ptr = 0;
        repeat (3) @(negedge clk);
        check("reset_hold_busy", 32'(busy_o), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        raise_req(2);
        raise_req(3);
        g = next_grant();
        plan_transfer(g, int'(O_ACK));
        wait_resp(g, 0);
        req_i[2] = 1'b0;
        g = next_grant();
        plan_transfer(g, int'(O_ACK));
        wait_resp(g, 0);
        req_i[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkOutput();
        check("final_busy", 32'(busy_o), 32'd0);
        check("final_sq_empty", sq.size(), 0);
        check("final_rq_empty", rq.size(), 0);
        check("final_mq_empty", mq.size(), 0);
    endtask

    initial begin : stimulus
        $display("[TB] starting i2c_txn_arbiter bench");
        #1 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus();
        checkOutput();
        finish_run();
    end

    initial begin : global_guard
        #1000000;
        check("global_timeout", 32'd0, 32'd1);
        finish_run();
    end

endmodule
